// File: rtl/alu_opsel_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_opsel_stage
// Operand-A select between ID and EX, with forwarding, load-use stall and a
// valid/ready output slot.
// Rev    : 1.0
// ============================================================================
module alu_opsel_stage #(
    parameter int XLEN     = 64,
    parameter int NUM_FWD  = 2,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                asel,
    input  logic [XLEN-1:0]           pc,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           imm,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           a_out,
    output logic                      a_fwd_hit,
    output logic [STALL_CW-1:0]       stall_cnt
);

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_REG  = 2'd1;
    localparam logic [1:0] SEL_PC   = 2'd2;
    localparam logic [1:0] SEL_IMM  = 2'd3;

    logic [REG_AW-1:0] rd_arr   [NUM_FWD];
    logic [XLEN-1:0]   data_arr [NUM_FWD];

    generate
        for (genvar g = 0; g < NUM_FWD; g++) begin : g_unpack
            assign rd_arr[g]   = fwd_rd[g*REG_AW +: REG_AW];
            assign data_arr[g] = fwd_data[g*XLEN +: XLEN];
        end
    endgenerate

    logic [XLEN-1:0] rs1_res;
    logic            rs1_hit;
    logic            rs1_pend;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] sel_val;
    logic            sel_hit;

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        rs1_res  = rs1_data;
        rs1_hit  = 1'b0;
        rs1_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (rd_arr[i] == rs1_addr)) begin
                rs1_res  = data_arr[i];
                rs1_hit  = 1'b1;
                rs1_pend = fwd_pending[i];
            end
        end
        if (rs1_addr == '0) begin
            rs1_res  = '0;
            rs1_hit  = 1'b0;
            rs1_pend = 1'b0;
        end
    end

    always_comb begin
        sel_val = '0;
        sel_hit = 1'b0;
        case (asel)
            SEL_ZERO: sel_val = '0;
            SEL_REG: begin
                sel_val = rs1_res;
                sel_hit = rs1_hit;
            end
            SEL_PC:   sel_val = pc;
            SEL_IMM:  sel_val = imm;
            default:  sel_val = '0;
        endcase
    end

    assign hazard   = (asel == SEL_REG) && rs1_pend;
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            a_fwd_hit <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a_out     <= sel_val;
            a_fwd_hit <= sel_hit;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(STALL_CW-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_opsel_stage.md
Name: alu_opsel_stage

Overview:
Parametrised operand-A select stage between ID and EX. Selects zero, register, PC or immediate as ALU operand A, and resolves register operands against N forwarding channels from later pipeline stages. Detects load-use hazards and stalls. Registers the selected operand in a valid/ready pipeline slot with flush support.

Parameters:
XLEN, 64, datapath width
NUM_FWD, 2, forwarding channels; index 0 is youngest and has highest priority
REG_AW, 5, register address width
STALL_CW, 16, width of the saturating stall counter

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  ID has an instruction
in_ready  out  1  stage accepts the instruction this cycle
asel  in  2  operand select: 0 ZERO, 1 REG, 2 PC, 3 IMM
pc  in  XLEN  instruction PC
rs1_addr  in  REG_AW  source register index
rs1_data  in  XLEN  register-file read value
imm  in  XLEN  decoded immediate
fwd_valid  in  NUM_FWD  channel i holds a pending write
fwd_rd  in  NUM_FWD*REG_AW  destination register per channel
fwd_data  in  NUM_FWD*XLEN  result per channel
fwd_pending  in  NUM_FWD  channel i result not yet available (load in flight)
flush  in  1  kill the held and the incoming instruction
out_valid  out  1  a_out is valid
out_ready  in  1  EX consumes a_out
a_out  out  XLEN  registered operand A
a_fwd_hit  out  1  registered: operand came from a forward channel
stall_cnt  out  STALL_CW  saturating count of hazard-stall cycles

Behaviour:
- Reset (rstn=0, async): out_valid=0, a_out=0, a_fwd_hit=0, stall_cnt=0. in_ready follows its combinational equation; out_valid=0 makes it 1 unless a hazard is present.
- Select: ZERO gives 0. PC gives pc. IMM gives imm. REG gives the resolved rs1.
- rs1 resolution: if rs1_addr==0, result is 0 and no channel is matched. Otherwise use the lowest index i with fwd_valid[i] && fwd_rd[i]==rs1_addr. On a match, result is fwd_data[i] and hit=1. With no match, result is rs1_data and hit=0.
- Hazard: asel==REG, rs1_addr!=0, matched channel i has fwd_pending[i]=1. A pending older channel is ignored when a younger channel matches and is not pending.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready && !flush. On accept, register a_out, a_fwd_hit and out_valid=1 next edge. Latency 1 cycle.
- If out_valid && out_ready && no accept, out_valid=0 next edge.
- If out_valid && !out_ready, hold a_out and a_fwd_hit stable.
- flush: out_valid=0 next edge and the incoming instruction is dropped. Flush has priority over accept and hold.
- stall_cnt increments each cycle in_valid && hazard && !flush. It saturates at all-ones and never wraps.
- Simultaneous consume and accept: out_valid stays 1 and a_out takes the new value (back-to-back throughput of 1/cycle).
- Reset asserted mid-hold clears everything immediately; no partial state survives.

Test Plan:
- Basic select with XLEN=64. asel=PC, pc=0x8000_0010. Then asel=IMM, imm=0xFFFF_FFFF_FFFF_FFF0. Then asel=ZERO. Required: a_out is 0x8000_0010, then 0xFFFF_FFFF_FFFF_FFF0, then 0, each one cycle after accept with out_ready=1.
- Forward priority. rs1_addr=5, rs1_data=0x11. fwd0: rd=5, data=0xAA. fwd1: rd=5, data=0xBB. Both valid, neither pending. Required: a_out=0xAA and a_fwd_hit=1. Repeat with fwd_valid=2'b10: a_out=0xBB. Repeat with fwd_valid=0: a_out=0x11 and hit=0.
- x0 guard. rs1_addr=0, fwd0 rd=0 valid with data 0x55 and pending=1. Required: no stall, a_out=0, hit=0.
- Load-use stall. fwd0 rd=7 pending, rs1_addr=7, asel=REG, held 3 cycles. Required: in_ready=0 for 3 cycles, stall_cnt=3. Then release with pending=0 and data=0x1234: a_out=0x1234 on the next edge.
- Backpressure plus flush. Accept 0x10 with out_ready=0 for 4 cycles: a_out holds 0x10 and in_ready=0. Then assert flush with in_valid=1: out_valid=0 next edge and nothing is accepted.
- Async reset mid-operation. out_valid=1 and stall_cnt=9; drop rstn between edges. Required: out_valid=0, a_out=0, stall_cnt=0 immediately, without waiting for a clock edge.
